// File: rtl/hist_dump_receiver_if.sv
// Bundle of the beat stream, host read port and status outputs of hist_dump_receiver.
// The master side drives beats and the read address; the slave side is the receiver.
interface hist_dump_receiver_if;
  logic [7:0] din;
  logic       din_valid;
  logic       din_last;
  logic [5:0] rd_addr;
  logic [3:0] rd_data;
  logic       have_frame;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic [7:0] frame_cnt;
  logic [9:0] total;
  logic [5:0] peak_bin;
  logic [3:0] peak_val;

  modport master (
    output din, din_valid, din_last, rd_addr,
    input  rd_data, have_frame, frame_ok, frame_err, err_code,
           frame_cnt, total, peak_bin, peak_val
  );

  modport slave (
    input  din, din_valid, din_last, rd_addr,
    output rd_data, have_frame, frame_ok, frame_err, err_code,
           frame_cnt, total, peak_bin, peak_val
  );
endinterface

// File: rtl/hist_dump_receiver.sv
// Double-buffered receiver for 64-beat histogram dumps with per-frame total/peak statistics.
// Frames land in the back bank and become host-visible only when complete and clean.
module hist_dump_receiver (
  input logic                 clk,
  input logic                 bin_reset,
  hist_dump_receiver_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [5:0] LAST_IDX  = 6'd63;
  localparam logic [1:0] ERR_SHORT = 2'b01;
  localparam logic [1:0] ERR_LONG  = 2'b10;
  localparam logic [1:0] ERR_NIB   = 2'b11;

  state_e     state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic       bank_q, bank_d;

  logic [3:0] bank0_q [64];
  logic [3:0] bank1_q [64];

  logic [9:0] sh_total_q, sh_total_d;
  logic [5:0] sh_pbin_q, sh_pbin_d;
  logic [3:0] sh_pval_q, sh_pval_d;
  logic       sh_bad_q, sh_bad_d;

  logic [3:0] rd_data_q;
  logic       have_q;
  logic       ok_q;
  logic       err_q;
  logic [1:0] code_q;
  logic [7:0] cnt_q;
  logic [9:0] total_q;
  logic [5:0] pbin_q;
  logic [3:0] pval_q;

  logic [3:0] beat_bin;
  logic       beat_bad;
  logic [9:0] base_total;
  logic [5:0] base_pbin;
  logic [3:0] base_pval;
  logic       base_bad;
  logic [9:0] acc_total;
  logic [5:0] acc_pbin;
  logic [3:0] acc_pval;
  logic       acc_bad;

  logic       we;
  logic       commit;
  logic       err_pulse;
  logic [1:0] err_code_d;

  function automatic logic [9:0] add_bin(input logic [9:0] sum, input logic [3:0] bin);
    return sum + {6'd0, bin};
  endfunction

  // Strictly greater only, so the earliest index wins a tie.
  function automatic logic peak_wins(input logic [3:0] cand, input logic [3:0] cur);
    return cand > cur;
  endfunction

  // Running statistics including the current beat; a frame's first beat starts from zero.
  always_comb begin
    beat_bin = bus.din[3:0];
    beat_bad = |bus.din[7:4];
    if (state_q == IDLE) begin
      base_total = '0;
      base_pbin  = '0;
      base_pval  = '0;
      base_bad   = 1'b0;
    end else begin
      base_total = sh_total_q;
      base_pbin  = sh_pbin_q;
      base_pval  = sh_pval_q;
      base_bad   = sh_bad_q;
    end
    acc_total = add_bin(base_total, beat_bin);
    acc_bad   = base_bad | beat_bad;
    if (peak_wins(beat_bin, base_pval)) begin
      acc_pbin = idx_q;
      acc_pval = beat_bin;
    end else begin
      acc_pbin = base_pbin;
      acc_pval = base_pval;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    bank_d     = bank_q;
    we         = 1'b0;
    commit     = 1'b0;
    err_pulse  = 1'b0;
    err_code_d = code_q;
    sh_total_d = sh_total_q;
    sh_pbin_d  = sh_pbin_q;
    sh_pval_d  = sh_pval_q;
    sh_bad_d   = sh_bad_q;

    unique case (state_q)
      IDLE: begin
        if (bus.din_valid) begin
          if (bus.din_last) begin
            err_pulse  = 1'b1;
            err_code_d = ERR_SHORT;
          end else begin
            we         = 1'b1;
            sh_total_d = acc_total;
            sh_pbin_d  = acc_pbin;
            sh_pval_d  = acc_pval;
            sh_bad_d   = acc_bad;
            idx_d      = 6'd1;
            state_d    = RECV;
          end
        end
      end

      RECV: begin
        if (bus.din_valid) begin
          if (bus.din_last) begin
            if (idx_q == LAST_IDX) begin
              we = 1'b1;
              if (acc_bad) begin
                err_pulse  = 1'b1;
                err_code_d = ERR_NIB;
              end else begin
                commit = 1'b1;
                bank_d = ~bank_q;
              end
            end else begin
              err_pulse  = 1'b1;
              err_code_d = ERR_SHORT;
            end
            idx_d   = '0;
            state_d = IDLE;
          end else if (idx_q == LAST_IDX) begin
            // A 64th beat without last means the frame is already too long.
            err_pulse  = 1'b1;
            err_code_d = ERR_LONG;
            idx_d      = '0;
            state_d    = DRAIN;
          end else begin
            we         = 1'b1;
            sh_total_d = acc_total;
            sh_pbin_d  = acc_pbin;
            sh_pval_d  = acc_pval;
            sh_bad_d   = acc_bad;
            idx_d      = idx_q + 6'd1;
          end
        end
      end

      DRAIN: begin
        if (bus.din_valid && bus.din_last) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge bin_reset) begin
    if (bin_reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      bank_q     <= 1'b0;
      sh_total_q <= '0;
      sh_pbin_q  <= '0;
      sh_pval_q  <= '0;
      sh_bad_q   <= 1'b0;
      rd_data_q  <= '0;
      have_q     <= 1'b0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= '0;
      cnt_q      <= '0;
      total_q    <= '0;
      pbin_q     <= '0;
      pval_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      bank_q     <= bank_d;
      sh_total_q <= sh_total_d;
      sh_pbin_q  <= sh_pbin_d;
      sh_pval_q  <= sh_pval_d;
      sh_bad_q   <= sh_bad_d;
      // Read uses the pre-swap select, so the swap cycle still shows the old frame.
      rd_data_q  <= bank_q ? bank1_q[bus.rd_addr] : bank0_q[bus.rd_addr];
      ok_q       <= commit;
      err_q      <= err_pulse;
      code_q     <= err_code_d;
      if (commit) begin
        have_q  <= 1'b1;
        cnt_q   <= cnt_q + 8'd1;
        total_q <= acc_total;
        pbin_q  <= acc_pbin;
        pval_q  <= acc_pval;
      end
    end
  end

  always_ff @(posedge clk or posedge bin_reset) begin
    if (bin_reset) begin
      for (int i = 0; i < 64; i++) begin
        bank0_q[i] <= '0;
        bank1_q[i] <= '0;
      end
    end else if (we) begin
      if (bank_q) begin
        bank0_q[idx_q] <= beat_bin;
      end else begin
        bank1_q[idx_q] <= beat_bin;
      end
    end
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.have_frame = have_q;
  assign bus.frame_ok   = ok_q;
  assign bus.frame_err  = err_q;
  assign bus.err_code   = code_q;
  assign bus.frame_cnt  = cnt_q;
  assign bus.total      = total_q;
  assign bus.peak_bin   = pbin_q;
  assign bus.peak_val   = pval_q;

endmodule

// File: doc/hist_dump_receiver.md
HIST_DUMP_RECEIVER -- requirements
Module: hist_dump_receiver

Interface
REQ-001 The block SHALL have no parameters; the frame length is fixed at 64 beats, and each bin is 4 bits wide.
REQ-002 Reset SHALL be bin_reset, asynchronous, active-high; the clock SHALL be clk.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 bin_reset  input  1  asynchronous active-high reset of all state and both banks.
REQ-005 din  input  8  dump beat; bits [3:0] are the bin count and bits [7:4] must be 0.
REQ-006 din_valid  input  1  din is a valid beat this cycle; gaps between beats are permitted.
REQ-007 din_last  input  1  final beat of a frame; qualified by din_valid.
REQ-008 rd_addr  input  6  host read address into the front bank.
REQ-009 rd_data  output  4  registered value of front[rd_addr], with 1-cycle latency.
REQ-010 have_frame  output  1  set when at least one good frame has been committed since reset.
REQ-011 frame_ok  output  1  single-cycle pulse when a good frame is committed.
REQ-012 frame_err  output  1  single-cycle pulse when a bad frame is discarded.
REQ-013 err_code  output  2  cause of the last error: 01 short, 10 long, 11 nonzero upper nibble; holds until the next error.
REQ-014 frame_cnt  output  8  count of good frames; wraps 255->0.
REQ-015 total  output  10  sum of the 64 bins of the front frame (maximum 960).
REQ-016 peak_bin  output  6  lowest index holding the maximum count in the front frame.
REQ-017 peak_val  output  4  the maximum count in the front frame.

Function
REQ-018 The block SHALL hold two 64x4 banks; front is host-visible and back receives; a 1-bit select bank swaps roles.
REQ-019 The FSM SHALL have three states: IDLE, RECV, DRAIN.
REQ-020 In IDLE, with index=0: a valid beat without last SHALL write back[0], set index=1, and move to RECV.
REQ-021 In IDLE, a valid beat with last (length 1) SHALL pulse frame_err with err_code=01 and remain in IDLE.
REQ-022 In RECV, each valid non-last beat SHALL write back[index] and increment index; cycles with din_valid=0 SHALL change nothing.
REQ-023 In RECV, a valid last beat at index==63 SHALL write back[63], then commit.
REQ-024 Commit SHALL, in the next cycle: swap banks, update total/peak_bin/peak_val, increment frame_cnt, pulse frame_ok, set have_frame, and return to IDLE with index=0.
REQ-025 In RECV, a valid last beat at index<63 SHALL pulse frame_err with err_code=01, discard the frame (no swap, statistics unchanged), and return to IDLE.
REQ-026 In RECV, a valid non-last beat at index==63 (a 65th beat pending) SHALL pulse frame_err with err_code=10 and move to DRAIN.
REQ-027 In DRAIN, beats SHALL be ignored until a valid last beat, which returns the FSM to IDLE with no further pulse.
REQ-028 A beat with din[7:4]!=0 SHALL mark the frame bad; at its last beat the block SHALL pulse frame_err with err_code=11 instead of committing. Short or long errors take precedence over the nibble error.
REQ-029 Total and peak SHALL accumulate incrementally per beat in shadow registers, so no post-frame scan is needed.
REQ-030 The shadow accumulators SHALL clear on entry to a new frame.
REQ-031 The peak SHALL update only on a strictly greater value, so ties keep the lowest index.
REQ-032 For an all-zero frame, the peak outputs SHALL be peak_bin=0 and peak_val=0.
REQ-033 frame_ok and frame_err SHALL never assert in the same cycle.
REQ-034 In the swap cycle, rd_data SHALL return the pre-swap front value; the new frame is readable from the following cycle.
REQ-035 The block SHALL apply no backpressure; every beat presented is consumed or discarded.

Reset
REQ-036 While bin_reset is asserted, all outputs SHALL be 0: rd_data, have_frame, frame_ok, frame_err, err_code, frame_cnt, total, peak_bin, peak_val.
REQ-037 While bin_reset is asserted, both banks SHALL clear, bank select SHALL be 0, index SHALL be 0, and the state SHALL be IDLE.
REQ-038 Reset asserted mid-frame SHALL abandon the frame with no pulse; the first valid beat after deassertion starts a new frame at index 0.

Verification
REQ-039 Good frame: bin i = i%16 for i=0..63, last on beat 63 -> frame_ok 1 cycle, frame_cnt=1, total=480, peak_bin=15, peak_val=15; rd_addr=17 returns 1.
REQ-040 Short frame: 10 beats, last on beat 9 -> frame_err with err_code=01; frame_cnt, total, and front-bank contents unchanged.
REQ-041 Long frame: 70 beats, last on beat 69 -> frame_err at beat 64 with err_code=10, no frame_ok; the next good frame commits normally.
REQ-042 Gaps and ties: 64 beats with random din_valid gaps, bins 3 and 40 both equal to 9 and all others 0 -> frame_ok, total=18, peak_bin=3, peak_val=9.
REQ-043 Nibble error: beat 5 = 8'h1F in an otherwise good frame -> frame_err with err_code=11, no swap.
REQ-044 Reset and wrap: assert bin_reset at beat 30 -> all outputs 0, no pulse; then 256 good frames -> frame_cnt=0 and have_frame=1.
